// File: rtl/trig_ctl_pkg.sv
// Shared encodings for the trigger controller: per-channel output modes,
// global edge qualification and the edge-qualify helper.
package trig_ctl_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_LEVEL  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  function automatic logic edge_qual(input logic [1:0] sel, input logic rise, input logic fall);
    logic q;
    q = 1'b0;
    case (sel)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/trig_ctl_if.sv
// Trigger-controller bus: asynchronous trigger inputs, configuration, clear,
// and the registered per-channel control/strobe outputs.
interface trig_ctl_if #(
  parameter int unsigned CH = 4
);
  logic [CH-1:0]   si;
  logic [2*CH-1:0] mode;
  logic [1:0]      edge_sel;
  logic            clr;
  logic [CH-1:0]   csen;
  logic [CH-1:0]   evt;

  modport master (output si, mode, edge_sel, clr, input csen, evt);
  modport slave  (input si, mode, edge_sel, clr, output csen, evt);
endinterface

// File: rtl/trig_ctl_chan.sv
// One trigger channel: 2-FF sync, optional debounce (TRIG_CTL_DEBOUNCE_EN),
// edge detect, mode-dependent control output and retriggerable pulse counter.
module trig_ctl_chan
  import trig_ctl_pkg::*;
#(
  parameter int unsigned DEB_CNT   = 8,
  parameter int unsigned PULSE_LEN = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       si_i,
  input  logic [1:0] mode_i,
  input  logic [1:0] edge_sel_i,
  input  logic       clr_i,
  output logic       csen_o,
  output logic       evt_o
);

  localparam int unsigned PW = $clog2(PULSE_LEN + 1);

  logic          s1_q, s2_q, p_q, f;
  logic          rise, fall, qual;
  logic          csen_d, csen_q, evt_d, evt_q;
  logic [PW-1:0] cnt_d, cnt_q;

`ifdef TRIG_CTL_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CNT + 1);

  logic          f_d, f_q;
  logic [DW-1:0] deb_d, deb_q;

  // Any cycle where s2 agrees with f restarts the stability count.
  always_comb begin
    f_d   = f_q;
    deb_d = '0;
    if (s2_q != f_q) begin
      if (deb_q == DW'(DEB_CNT - 1)) begin
        f_d = s2_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_q   <= 1'b0;
      deb_q <= '0;
    end else begin
      f_q   <= f_d;
      deb_q <= deb_d;
    end
  end

  assign f = f_q;
`else
  assign f = s2_q;
`endif

  assign rise = f & ~p_q;
  assign fall = ~f & p_q;
  assign qual = edge_qual(edge_sel_i, rise, fall);

  always_comb begin
    csen_d = csen_q;
    cnt_d  = '0;
    evt_d  = qual;
    case (mode_i)
      MODE_TOGGLE: if (qual) csen_d = ~csen_q;
      MODE_PULSE: begin
        cnt_d = cnt_q;
        if (qual) begin
          cnt_d  = PW'(PULSE_LEN);
          csen_d = 1'b1;
        end else if (cnt_q != '0) begin
          // Drop on the cycle the counter reaches zero: high PULSE_LEN cycles.
          cnt_d  = cnt_q - 1'b1;
          csen_d = (cnt_q > PW'(1));
        end
      end
      MODE_LEVEL:  csen_d = f;
      default:     csen_d = csen_q;
    endcase
    if (clr_i) begin
      csen_d = 1'b0;
      evt_d  = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      p_q    <= 1'b0;
      csen_q <= 1'b0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= si_i;
      s2_q   <= s1_q;
      p_q    <= f;
      csen_q <= csen_d;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign csen_o = csen_q;
  assign evt_o  = evt_q;

endmodule

// File: rtl/trig_ctl.sv
// Multi-channel trigger controller top: CH independent trig_ctl_chan slices.
// Optional input debounce is enabled by defining TRIG_CTL_DEBOUNCE_EN.
module trig_ctl
  import trig_ctl_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned DEB_CNT   = 8,
  parameter int unsigned PULSE_LEN = 16
) (
  input logic          clk24m,
  input logic          rst_n,
  trig_ctl_if.slave    bus
);

  if (CH < 1 || CH > 16 || DEB_CNT < 1 || DEB_CNT > 255 ||
      PULSE_LEN < 1 || PULSE_LEN > 65535) begin : g_bad_param
    $error("trig_ctl: parameter out of range");
  end

  logic [CH-1:0] csen;
  logic [CH-1:0] evt;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    trig_ctl_chan #(
      .DEB_CNT   (DEB_CNT),
      .PULSE_LEN (PULSE_LEN)
    ) u_chan (
      .clk_i      (clk24m),
      .rst_ni     (rst_n),
      .si_i       (bus.si[i]),
      .mode_i     (bus.mode[2*i +: 2]),
      .edge_sel_i (bus.edge_sel),
      .clr_i      (bus.clr),
      .csen_o     (csen[i]),
      .evt_o      (evt[i])
    );
  end

  assign bus.csen = csen;
  assign bus.evt  = evt;

endmodule

// File: doc/trig_ctl.md
TRIG_CTL -- requirements
Module: trig_ctl

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent trigger channels (1..16).
REQ-002 SHALL have parameter DEB_CNT, default 8: debounce stability length in clk24m cycles (1..255).
REQ-003 SHALL have parameter PULSE_LEN, default 16: one-shot output width in clk24m cycles (1..65535).
REQ-004 SHALL have port clk24m  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port si  in  CH  asynchronous trigger inputs, one per channel.
REQ-007 SHALL have port mode  in  2*CH  per-channel mode, bits [2i+1:2i] for channel i: 00 toggle, 01 pulse, 10 level, 11 hold.
REQ-008 SHALL have port edge_sel  in  2  global qualifying edge: 00 rising, 01 falling, 10 both, 11 none.
REQ-009 SHALL have port clr  in  1  synchronous clear of all channel outputs and counters.
REQ-010 SHALL have port csen  out  CH  registered per-channel control outputs.
REQ-011 SHALL have port evt  out  CH  registered single-cycle strobe per qualified edge.

Function
REQ-012 SHALL pass each si bit through a 2-FF synchronizer (s1, s2) and a previous-value register p.
REQ-013 SHALL detect edges on the filtered level f vs p: rising = f & !p, falling = !f & p; qualified edge per edge_sel.
REQ-014 SHALL, in toggle mode, invert csen[i] on each qualified edge.
REQ-015 SHALL, in pulse mode, load a per-channel down-counter with PULSE_LEN on a qualified edge and drive csen[i]=1 while counter != 0; an edge during an active pulse reloads PULSE_LEN (retrigger).
REQ-016 SHALL, in level mode, drive csen[i] = f registered one cycle; edge_sel ignored for csen, still applied to evt.
REQ-017 SHALL, in hold mode, freeze csen[i]; evt still generated.
REQ-018 SHALL assert evt[i] for exactly one cycle per qualified edge, coincident with the csen update.
REQ-019 SHALL, on mode change, keep csen[i] at its current value; leaving pulse mode clears the pulse counter.
REQ-020 SHALL give clr priority over any same-cycle edge: csen=0, pulse counters=0, evt=0 on the next edge.
REQ-021 SHALL, without debounce, update csen/evt on the 3rd rising clk24m edge after si is first sampled at the new level.
REQ-022 SHALL treat channels fully independently; simultaneous edges on several channels each act in the same cycle.

Reset
REQ-023 SHALL on rst_n low asynchronously clear s1, s2, p, f, debounce and pulse counters, csen and evt to 0.
REQ-024 SHALL, after rst_n release, not report an edge for an si held high through reset until f has been 0 first is NOT required: an si held high SHALL produce one rising edge after synchronizer/debounce latency.

Configuration
REQ-025 SHALL with TRIG_CTL_DEBOUNCE_EN defined: f changes only after s2 differs from f for DEB_CNT consecutive cycles (counter restarts on any glitch), adding DEB_CNT cycles latency.
REQ-026 SHALL without TRIG_CTL_DEBOUNCE_EN: f = s2, no debounce counter instantiated, DEB_CNT unused.

Structure
REQ-027 SHALL place mode encodings (MODE_TOGGLE/PULSE/LEVEL/HOLD) and edge_sel encodings in shared package trig_ctl_pkg.
REQ-028 SHALL implement one channel (sync, debounce, edge detect, mode output, pulse counter) in sub-module trig_ctl_chan, generated CH times.
REQ-029 SHALL size debounce counter $clog2(DEB_CNT+1) bits and pulse counter $clog2(PULSE_LEN+1) bits; no wrap-around permitted.

Verification
REQ-030 SHALL cover: toggle, rising, no debounce, si[0] 0->1 at cycle 0 -> csen[0]=1 and evt[0]=1 at cycle 3; second rising edge -> csen[0]=0.
REQ-031 SHALL cover: pulse, PULSE_LEN=16, rising edge -> csen high exactly 16 cycles; retrigger at cycle 10 -> high through cycle 26.
REQ-032 SHALL cover: debounce on, DEB_CNT=8, 5-cycle glitch -> no evt, csen unchanged; 8-cycle stable high -> one evt.
REQ-033 SHALL cover: edge_sel=both, toggle, si 0->1->0 -> two evt, csen returns to 0.
REQ-034 SHALL cover: clr asserted same cycle as qualified edge on all CH channels -> csen=0, evt=0.
REQ-035 SHALL cover: rst_n asserted mid-pulse (cycle 5 of 16) -> csen=0 immediately, no pulse resumes after release.
